id_issue_ctrl: RTL and testbench

//  ID-stage issue controller between IF and EX of the RV32I pipeline.

---
 rtl/rv_isa_pkg.sv | 49 ++++
 rtl/id_issue_ctrl_if.sv | 31 +++
 rtl/id_scoreboard.sv | 47 ++++
 rtl/id_issue_ctrl.sv | 83 ++++++++
 tb/tb_id_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I decode helpers shared by the ID stage: opcodes, register index type,
// and the per-opcode register-usage lookup.
package rv_isa_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
  } reg_use_t;

  // Unknown opcodes report no register use so they can never stall.
  function automatic reg_use_t reg_use(input logic [6:0] opcode);
    reg_use_t u;
    u = '0;
    case (opcode)
      OPC_OP: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        u.use_rs1 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        u.use_rd = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// IF -> ID -> EX handshake bundle plus the writeback retire port.
// slave = the ID issue controller, master = the surrounding pipeline.
interface id_issue_ctrl_if #(
  parameter int unsigned BITS = 32
);
  import rv_isa_pkg::*;

  logic            IF_VALID;
  logic [BITS-1:0] IF_INSTR;
  logic [BITS-1:0] IF_PC;
  logic            id_ready;
  logic            FLUSH;
  logic            EX_READY;
  logic            ex_valid;
  logic [BITS-1:0] ex_instr;
  logic [BITS-1:0] ex_pc;
  logic            WB_VALID;
  reg_idx_t        WB_RD;
  logic            stall_hazard;

  modport master (
    output IF_VALID, IF_INSTR, IF_PC, FLUSH, EX_READY, WB_VALID, WB_RD,
    input  id_ready, ex_valid, ex_instr, ex_pc, stall_hazard
  );

  modport slave (
    input  IF_VALID, IF_INSTR, IF_PC, FLUSH, EX_READY, WB_VALID, WB_RD,
    output id_ready, ex_valid, ex_instr, ex_pc, stall_hazard
  );

endinterface

// File: rtl/id_scoreboard.sv
// 32-entry pending-write scoreboard with hazard lookup for one instruction.
// Optional macro ID_WB_BYPASS_EN masks the register retiring this cycle.
module id_scoreboard
  import rv_isa_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_use_t use_i,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  output logic     hit
);

  logic [31:0] sb_q;
  logic [31:0] sb_d;
  logic [31:0] pend;

  // Set is applied after clear so a new writer outlives a stale retire.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    if (set_en) sb_d[set_idx] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    pend = sb_q;
`ifdef ID_WB_BYPASS_EN
    // Relies on the register file writing before it is read in the same cycle.
    if (clr_en) pend[clr_idx] = 1'b0;
`endif
    hit = (use_i.use_rs1 & pend[rs1]) |
          (use_i.use_rs2 & pend[rs2]) |
          (use_i.use_rd  & pend[rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: IF/ID holding register, field slicing, hazard-gated
// issue to EX. Optional macro ID_WB_BYPASS_EN (handled in id_scoreboard).
module id_issue_ctrl
  import rv_isa_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input logic            CLK,
  input logic            RST_N,
  id_issue_ctrl_if.slave bus
);

  logic            hold_valid_q, hold_valid_d;
  logic [BITS-1:0] hold_instr_q, hold_instr_d;
  logic [BITS-1:0] hold_pc_q,    hold_pc_d;

  reg_idx_t rs1, rs2, rd;
  reg_use_t use_w;
  logic     sb_hit;
  logic     hazard;
  logic     ex_valid;
  logic     issue;
  logic     id_ready;
  logic     load;

  assign rd    = hold_instr_q[11:7];
  assign rs1   = hold_instr_q[19:15];
  assign rs2   = hold_instr_q[24:20];
  assign use_w = reg_use(hold_instr_q[6:0]);

  assign hazard   = hold_valid_q & sb_hit;
  assign ex_valid = hold_valid_q & ~hazard & ~bus.FLUSH;
  assign issue    = ex_valid & bus.EX_READY;
  assign id_ready = ~hold_valid_q | issue | bus.FLUSH;
  assign load     = id_ready & bus.IF_VALID & ~bus.FLUSH;

  id_scoreboard u_sb (
    .clk     (CLK),
    .rst_n   (RST_N),
    .set_en  (issue & use_w.use_rd),
    .set_idx (rd),
    .clr_en  (bus.WB_VALID),
    .clr_idx (bus.WB_RD),
    .use_i   (use_w),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .hit     (sb_hit)
  );

  // A load in the issue cycle refills the slot, giving zero-bubble issue.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (load) begin
      hold_valid_d = 1'b1;
      hold_instr_d = bus.IF_INSTR;
      hold_pc_d    = bus.IF_PC;
    end else if (issue || bus.FLUSH) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = ex_valid;
  assign bus.ex_instr     = hold_instr_q;
  assign bus.ex_pc        = hold_pc_q;
  assign bus.stall_hazard = hazard;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios plus a randomized
// run against an opcode-table / pending-array reference model.
module tb_id_issue_ctrl;

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADD_X2  = 32'h00108133;
  localparam logic [31:0] LW_X5   = 32'h0002a283;
  localparam logic [31:0] ADDI_X3 = 32'h00100193;
  localparam logic [31:0] NOP     = 32'h00000013;

  logic CLK;
  logic RST_N;
  int   checks = 0;
  int   passed = 0;

  always begin
    CLK = 1'b0; #5;
    CLK = 1'b1; #5;
  end

  id_issue_ctrl_if #(.BITS(32)) bus ();

  id_issue_ctrl #(.BITS(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  task automatic drive_idle();
    bus.IF_VALID = 1'b0;
    bus.IF_INSTR = '0;
    bus.IF_PC    = '0;
    bus.FLUSH    = 1'b0;
    bus.EX_READY = 1'b0;
    bus.WB_VALID = 1'b0;
    bus.WB_RD    = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    RST_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // {use_rs1, use_rs2, use_rd} from opcode membership lists.
  function automatic logic [2:0] tb_uses(input logic [6:0] op);
    logic r1, r2, wd;
    r1 = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
    r2 = op inside {7'h33, 7'h23, 7'h63};
    wd = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6f};
    return {r1, r2, wd};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    case ($urandom_range(0, 9))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h67;
      4: op = 7'h23;
      5: op = 7'h63;
      6: op = 7'h37;
      7: op = 7'h17;
      8: op = 7'h6f;
      default: op = 7'h73;
    endcase
    w = $urandom;
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_reset();
    drive_idle();
    RST_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid got=%b exp=0", bus.ex_valid); else passed++;
    checks++; if (bus.ex_instr !== 32'h0) $display("FAIL reset_ex_instr got=%h exp=0", bus.ex_instr); else passed++;
    checks++; if (bus.ex_pc !== 32'h0) $display("FAIL reset_ex_pc got=%h exp=0", bus.ex_pc); else passed++;
    checks++; if (bus.id_ready !== 1'b1) $display("FAIL reset_id_ready got=%b exp=1", bus.id_ready); else passed++;
    checks++; if (bus.stall_hazard !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall_hazard); else passed++;
    checks++; if (dut.u_sb.sb_q !== 32'h0) $display("FAIL reset_sb got=%h exp=0", dut.u_sb.sb_q); else passed++;
    RST_N = 1'b1;
  endtask

  task automatic test_basic_issue();
    do_reset();
    bus.IF_VALID = 1'b1; bus.IF_INSTR = ADDI_X1; bus.IF_PC = 32'h100; bus.EX_READY = 1'b1;
    #1;
    checks++; if (bus.id_ready !== 1'b1) $display("FAIL t1_accept_ready got=%b exp=1", bus.id_ready); else passed++;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL t1_pre_ex_valid got=%b exp=0", bus.ex_valid); else passed++;
    next_cycle();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL t1_ex_valid got=%b exp=1", bus.ex_valid); else passed++;
    checks++; if (bus.ex_instr !== ADDI_X1) $display("FAIL t1_ex_instr got=%h exp=%h", bus.ex_instr, ADDI_X1); else passed++;
    checks++; if (bus.ex_pc !== 32'h100) $display("FAIL t1_ex_pc got=%h exp=100", bus.ex_pc); else passed++;
    next_cycle();
    checks++; if (dut.u_sb.sb_q !== 32'h2) $display("FAIL t1_sb got=%h exp=2", dut.u_sb.sb_q); else passed++;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL t1_drained got=%b exp=0", bus.ex_valid); else passed++;
  endtask

  task automatic test_raw_stall();
    do_reset();
    bus.IF_VALID = 1'b1; bus.IF_INSTR = ADDI_X1; bus.IF_PC = 32'h200; bus.EX_READY = 1'b1;
    next_cycle();
    bus.IF_INSTR = ADD_X2; bus.IF_PC = 32'h204;
    #1;
    checks++; if ({bus.ex_valid, bus.id_ready} !== 2'b11) $display("FAIL t2_b2b got=%b exp=11", {bus.ex_valid, bus.id_ready}); else passed++;
    next_cycle();
    bus.IF_VALID = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.stall_hazard, bus.ex_valid, bus.id_ready} !== 3'b100) $display("FAIL t2_stall[%0d] got=%b exp=100", i, {bus.stall_hazard, bus.ex_valid, bus.id_ready}); else passed++;
      next_cycle();
    end
    checks++; if (bus.ex_instr !== ADD_X2) $display("FAIL t2_held got=%h exp=%h", bus.ex_instr, ADD_X2); else passed++;
    bus.WB_VALID = 1'b1; bus.WB_RD = 5'd1;
    #1;
`ifdef ID_WB_BYPASS_EN
    checks++; if ({bus.stall_hazard, bus.ex_valid} !== 2'b01) $display("FAIL t2_wb_cycle got=%b exp=01", {bus.stall_hazard, bus.ex_valid}); else passed++;
    next_cycle();
    bus.WB_VALID = 1'b0;
    #1;
`else
    checks++; if ({bus.stall_hazard, bus.ex_valid} !== 2'b10) $display("FAIL t2_wb_cycle got=%b exp=10", {bus.stall_hazard, bus.ex_valid}); else passed++;
    next_cycle();
    bus.WB_VALID = 1'b0;
    #1;
    checks++; if ({bus.stall_hazard, bus.ex_valid} !== 2'b01) $display("FAIL t2_after_wb got=%b exp=01", {bus.stall_hazard, bus.ex_valid}); else passed++;
    next_cycle();
`endif
    checks++; if (dut.u_sb.sb_q !== 32'h4) $display("FAIL t2_sb got=%h exp=4", dut.u_sb.sb_q); else passed++;
    checks++; if ({bus.ex_valid, bus.id_ready} !== 2'b01) $display("FAIL t2_done got=%b exp=01", {bus.ex_valid, bus.id_ready}); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.IF_VALID = 1'b1; bus.IF_INSTR = LW_X5; bus.IF_PC = 32'h300; bus.EX_READY = 1'b0;
    next_cycle();
    bus.IF_INSTR = ADDI_X1; bus.IF_PC = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus.ex_valid, bus.id_ready} !== 2'b10) $display("FAIL t3_hold[%0d] got=%b exp=10", i, {bus.ex_valid, bus.id_ready}); else passed++;
      checks++; if (bus.ex_instr !== LW_X5) $display("FAIL t3_instr[%0d] got=%h exp=%h", i, bus.ex_instr, LW_X5); else passed++;
      checks++; if (dut.u_sb.sb_q[5] !== 1'b0) $display("FAIL t3_sb5[%0d] got=%b exp=0", i, dut.u_sb.sb_q[5]); else passed++;
      next_cycle();
    end
    bus.IF_VALID = 1'b0; bus.EX_READY = 1'b1;
    #1;
    checks++; if ({bus.ex_valid, bus.id_ready} !== 2'b11) $display("FAIL t3_issue got=%b exp=11", {bus.ex_valid, bus.id_ready}); else passed++;
    next_cycle();
    checks++; if (dut.u_sb.sb_q !== 32'h20) $display("FAIL t3_sb got=%h exp=20", dut.u_sb.sb_q); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    bus.IF_VALID = 1'b1; bus.IF_INSTR = ADDI_X1; bus.EX_READY = 1'b1;
    next_cycle();
    bus.IF_INSTR = LW_X5;
    next_cycle();
    bus.IF_INSTR = ADD_X2; bus.EX_READY = 1'b0; bus.FLUSH = 1'b1;
    #1;
    checks++; if ({bus.ex_valid, bus.id_ready} !== 2'b01) $display("FAIL t4_flush_cycle got=%b exp=01", {bus.ex_valid, bus.id_ready}); else passed++;
    next_cycle();
    bus.FLUSH = 1'b0; bus.IF_VALID = 1'b0;
    #1;
    checks++; if ({bus.ex_valid, bus.id_ready, bus.stall_hazard} !== 3'b010) $display("FAIL t4_after got=%b exp=010", {bus.ex_valid, bus.id_ready, bus.stall_hazard}); else passed++;
    checks++; if (dut.u_sb.sb_q !== 32'h2) $display("FAIL t4_sb got=%h exp=2", dut.u_sb.sb_q); else passed++;
  endtask

  task automatic test_set_wins();
    do_reset();
    bus.IF_VALID = 1'b1; bus.IF_INSTR = ADDI_X3; bus.EX_READY = 1'b1;
    next_cycle();
    bus.IF_VALID = 1'b0; bus.WB_VALID = 1'b1; bus.WB_RD = 5'd3;
    #1;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL t5_issue got=%b exp=1", bus.ex_valid); else passed++;
    next_cycle();
    bus.WB_VALID = 1'b0;
    checks++; if (dut.u_sb.sb_q !== 32'h8) $display("FAIL t5_set_wins got=%h exp=8", dut.u_sb.sb_q); else passed++;
    bus.IF_VALID = 1'b1; bus.IF_INSTR = NOP;
    next_cycle();
    bus.IF_VALID = 1'b0; bus.WB_VALID = 1'b1; bus.WB_RD = 5'd0;
    #1;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL t5_x0_issue got=%b exp=1", bus.ex_valid); else passed++;
    next_cycle();
    bus.WB_VALID = 1'b0;
    checks++; if (dut.u_sb.sb_q !== 32'h8) $display("FAIL t5_x0_sb got=%h exp=8", dut.u_sb.sb_q); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.IF_VALID = 1'b1; bus.IF_INSTR = ADDI_X1; bus.EX_READY = 1'b1;
    next_cycle();
    bus.IF_INSTR = ADD_X2;
    next_cycle();
    bus.IF_VALID = 1'b0;
    #1;
    checks++; if (bus.stall_hazard !== 1'b1) $display("FAIL t6_pre_stall got=%b exp=1", bus.stall_hazard); else passed++;
    #1;
    RST_N = 1'b0;
    #1;
    checks++; if ({bus.ex_valid, bus.id_ready, bus.stall_hazard} !== 3'b010) $display("FAIL t6_async got=%b exp=010", {bus.ex_valid, bus.id_ready, bus.stall_hazard}); else passed++;
    checks++; if (dut.u_sb.sb_q !== 32'h0) $display("FAIL t6_sb got=%h exp=0", dut.u_sb.sb_q); else passed++;
    next_cycle();
    RST_N = 1'b1;
  endtask

  task automatic test_random();
    logic        m_hold;
    logic [31:0] m_instr, m_pc, m_sb, look;
    logic [2:0]  u;
    logic        haz, e_exv, e_idr, iss;
    do_reset();
    m_hold = 1'b0; m_instr = '0; m_pc = '0; m_sb = '0;
    for (int n = 0; n < 600; n++) begin
      bus.IF_VALID = ($urandom_range(0, 99) < 70);
      bus.IF_INSTR = rand_instr();
      bus.IF_PC    = $urandom;
      bus.EX_READY = ($urandom_range(0, 99) < 75);
      bus.FLUSH    = ($urandom_range(0, 99) < 8);
      bus.WB_VALID = ($urandom_range(0, 99) < 35);
      bus.WB_RD    = 5'($urandom_range(0, 3));
      #1;
      u = tb_uses(m_instr[6:0]);
      look = m_sb;
`ifdef ID_WB_BYPASS_EN
      if (bus.WB_VALID) look[bus.WB_RD] = 1'b0;
`endif
      haz = m_hold && ((u[2] && look[m_instr[19:15]]) || (u[1] && look[m_instr[24:20]]) ||
                       (u[0] && look[m_instr[11:7]]));
      e_exv = m_hold && !haz && !bus.FLUSH;
      e_idr = !m_hold || (e_exv && bus.EX_READY) || bus.FLUSH;
      checks++; if ({bus.ex_valid, bus.id_ready, bus.stall_hazard} !== {e_exv, e_idr, haz})
        $display("FAIL rnd_ctrl[%0d] got=%b exp=%b", n, {bus.ex_valid, bus.id_ready, bus.stall_hazard}, {e_exv, e_idr, haz}); else passed++;
      checks++; if ({bus.ex_instr, bus.ex_pc} !== {m_instr, m_pc})
        $display("FAIL rnd_data[%0d] got=%h/%h exp=%h/%h", n, bus.ex_instr, bus.ex_pc, m_instr, m_pc); else passed++;
      @(posedge CLK);
      iss = e_exv && bus.EX_READY;
      if (bus.WB_VALID) m_sb[bus.WB_RD] = 1'b0;
      if (iss && u[0]) m_sb[m_instr[11:7]] = 1'b1;
      m_sb[0] = 1'b0;
      if (e_idr && bus.IF_VALID && !bus.FLUSH) begin
        m_hold = 1'b1; m_instr = bus.IF_INSTR; m_pc = bus.IF_PC;
      end else if (iss || bus.FLUSH) begin
        m_hold = 1'b0;
      end
      #1;
      checks++; if (dut.u_sb.sb_q !== m_sb) $display("FAIL rnd_sb[%0d] got=%h exp=%h", n, dut.u_sb.sb_q, m_sb); else passed++;
    end
    drive_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_backpressure();
    test_flush();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
